// File: rtl/seg_scan_driver_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display blocks.
// Anode and decimal-point lines are active-low on the common-anode board.
package seg_scan_driver_pkg;

  localparam logic ANODE_ON  = 1'b0;
  localparam logic ANODE_OFF = 1'b1;
  localparam logic DP_ON     = 1'b0;
  localparam logic DP_OFF    = 1'b1;

  localparam int DEFAULT_NUM_DIGITS = 4;

  // Bits needed to hold 0..n-1, never less than one so single-value counters still exist.
  function automatic int clog2(input int n);
    int w;
    for (w = 1; (1 << w) < n; w++) begin
    end
    return w;
  endfunction

endpackage

// File: rtl/seg_scan_driver_scan_tick_gen.sv
// Digit-slot prescaler: counts REFRESH_DIV clocks per slot and flags the last one.
// Exposes both the current and next count so the caller can register outputs from next state.
module scan_tick_gen
  import seg_scan_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int CW          = clog2(REFRESH_DIV)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] cnt_nxt,
  output logic          slot_tick
);

  // NOTE: combinational outputs get a full assignment on every path so no latch is inferred.
  always_comb begin
    slot_tick = (cnt == CW'(REFRESH_DIV - 1));
    cnt_nxt   = slot_tick ? '0 : cnt + CW'(1);
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_nxt;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with per-frame value latching,
// leading-zero suppression and a blanking interval at the start of every slot.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS   = DEFAULT_NUM_DIGITS,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  output logic [3:0]              hex,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int CW = clog2(REFRESH_DIV);
  localparam int IW = clog2(NUM_DIGITS);

  logic [CW-1:0]           cnt, cnt_nxt;
  logic                    slot_tick;
  logic [IW-1:0]           idx, idx_nxt;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_nxt;
  logic [NUM_DIGITS-1:0]   dp_sh, dp_sh_nxt;
  logic                    lz_sh, lz_sh_nxt;
  logic                    frame_end;

  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    upper_zero;
  logic                    lit;
  logic [3:0]              hex_d;
  logic [NUM_DIGITS-1:0]   an_d;
  logic                    dp_d;
  logic                    fs_d;

  scan_tick_gen #(
    .REFRESH_DIV (REFRESH_DIV),
    .CW          (CW)
  ) u_tick (
    .clk       (clk),
    .reset     (reset),
    .cnt       (cnt),
    .cnt_nxt   (cnt_nxt),
    .slot_tick (slot_tick)
  );

  // Next-state: digit index and the frame shadow, which only moves on the last cycle of a frame.
  always_comb begin
    frame_end  = slot_tick && (idx == IW'(NUM_DIGITS - 1));
    idx_nxt    = idx;
    if (slot_tick) idx_nxt = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    shadow_nxt = frame_end ? value : shadow;
    dp_sh_nxt  = frame_end ? dp_in : dp_sh;
    lz_sh_nxt  = frame_end ? lz_en : lz_sh;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx    <= '0;
      shadow <= '0;
      dp_sh  <= '0;
      lz_sh  <= 1'b0;
    end else begin
      idx    <= idx_nxt;
      shadow <= shadow_nxt;
      dp_sh  <= dp_sh_nxt;
      lz_sh  <= lz_sh_nxt;
    end
  end

  // Scan from the most significant digit down; digit 0 always shows so zero reads as "0".
  always_comb begin
    upper_zero = 1'b1;
    lz_blank   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero  = upper_zero && (shadow_nxt[4*i +: 4] == 4'h0);
      lz_blank[i] = lz_sh_nxt && upper_zero && (i != 0);
    end
  end

  always_comb begin
    hex_d = shadow_nxt[4*idx_nxt +: 4];
    lit   = (int'(cnt_nxt) >= BLANK_CYCLES) && !lz_blank[idx_nxt];
    an_d  = {NUM_DIGITS{ANODE_OFF}};
    if (lit) an_d[idx_nxt] = ANODE_ON;
    dp_d  = (lit && dp_sh_nxt[idx_nxt]) ? DP_ON : DP_OFF;
    fs_d  = (cnt_nxt == '0) && (idx_nxt == '0);
  end

  // Reset leaves the scanner on the first cycle of slot 0, so frame_start is already high.
  always_ff @(posedge clk) begin
    if (reset) begin
      hex         <= 4'h0;
      an          <= {NUM_DIGITS{ANODE_OFF}};
      dp          <= DP_OFF;
      frame_start <= 1'b1;
    end else begin
      hex         <= hex_d;
      an          <= an_d;
      dp          <= dp_d;
      frame_start <= fs_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: a 4-digit instance frame by frame, then a
// single-digit instance with no blanking interval.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic [3:0]  hex;
  logic [3:0]  an;
  logic        dp;
  logic        frame_start;

  logic [3:0]  value1;
  logic [0:0]  dp_in1;
  logic [3:0]  hex1;
  logic [0:0]  an1;
  logic        dp1;
  logic        frame_start1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1)) u_dut (
    .clk (clk), .reset (reset), .value (value), .dp_in (dp_in), .lz_en (lz_en),
    .hex (hex), .an (an), .dp (dp), .frame_start (frame_start)
  );

  seg_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(4), .BLANK_CYCLES(0)) u_dut1 (
    .clk (clk), .reset (reset), .value (value1), .dp_in (dp_in1), .lz_en (1'b0),
    .hex (hex1), .an (an1), .dp (dp1), .frame_start (frame_start1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One 16-cycle frame starting at its cycle-0 sample point. digits holds the expected
  // nibble per slot, lit which slots are enabled, dpm the decimal-point requests.
  // At cycle chg_at (if >=0) the inputs are changed after that cycle's checks.
  task automatic check_frame(input string tag, input logic [15:0] digits,
                             input logic [3:0] lit, input logic [3:0] dpm,
                             input int chg_at, input logic [15:0] nv,
                             input logic [3:0] ndp, input logic nlz);
    logic [3:0] exp_an;
    logic       exp_dp;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        exp_an = 4'hF;
        if (c >= 1 && lit[s]) exp_an[s] = 1'b0;
        exp_dp = (exp_an[s] == 1'b0 && dpm[s]) ? 1'b0 : 1'b1;
        check($sformatf("%s s%0d c%0d hex", tag, s, c), hex, digits[4*s +: 4]);
        check($sformatf("%s s%0d c%0d an", tag, s, c), an, exp_an);
        check($sformatf("%s s%0d c%0d dp", tag, s, c), dp, exp_dp);
        check($sformatf("%s s%0d c%0d fs", tag, s, c), frame_start, (s == 0 && c == 0));
        if (4*s + c == chg_at) begin
          value = nv;
          dp_in = ndp;
          lz_en = nlz;
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    value  = 16'h1234;
    dp_in  = 4'h0;
    lz_en  = 1'b0;
    value1 = 4'h0;
    dp_in1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check_frame("f0_reset_shadow", 16'h0000, 4'hF, 4'h0, -1, 16'h0, 4'h0, 1'b0);
    check_frame("f1_1234", 16'h1234, 4'hF, 4'h0, 6, 16'hABCD, 4'h0, 1'b0);
    check_frame("f2_abcd", 16'hABCD, 4'hF, 4'h0, 5, 16'h0050, 4'h0, 1'b1);
    check_frame("f3_lz_0050", 16'h0050, 4'h3, 4'h0, 5, 16'h0000, 4'h0, 1'b1);
    check_frame("f4_lz_0000", 16'h0000, 4'h1, 4'h0, 5, 16'h1234, 4'h4, 1'b0);
    check_frame("f5_dp2", 16'h1234, 4'hF, 4'h4, -1, 16'h0, 4'h0, 1'b0);

    // Reset for one edge at cycle 6 of a frame; the partial frame is discarded.
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_frame("post_rst", 16'h0000, 4'hF, 4'h0, -1, 16'h0, 4'h0, 1'b0);
    check_frame("post_rst_f1", 16'h1234, 4'hF, 4'h4, -1, 16'h0, 4'h0, 1'b0);

    // Single digit, no blanking: reload at every slot wrap.
    value1 = 4'h7;
    dp_in1 = 1'b1;
    reset  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("d1 c%0d fs", k), frame_start1, (k % 4 == 0));
      check($sformatf("d1 c%0d an", k), an1, (k == 0) ? 1'b1 : 1'b0);
      check($sformatf("d1 c%0d hex", k), hex1, (k < 4) ? 4'h0 : (k < 8) ? 4'h7 : 4'h9);
      check($sformatf("d1 c%0d dp", k), dp1, (k >= 4) ? 1'b0 : 1'b1);
      if (k == 5) value1 = 4'h9;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
